// File: rtl/a2d_pkg.sv
//------------------------------------------------------------------------------
// Module   : a2d_pkg
// Desc     : Shared constants and types for the emulated 8-channel SPI A2D.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package a2d_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 8;
    localparam int CH_LSB     = 11;

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int PAD_W = FRAME_BITS - DATA_W;

    typedef logic [2:0] ch_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } a2d_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_edge_sync.sv
//------------------------------------------------------------------------------
// Module   : spi_edge_sync
// Desc     : Two-flop synchronizer with a third flop for rise/fall detection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/a2d_spi_resp.sv
//------------------------------------------------------------------------------
// Module   : a2d_spi_resp
// Desc     : Oversampled SPI responder emulating an 8-channel 12-bit A2D.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module a2d_spi_resp
    import a2d_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] chan_data,
    output logic [2:0]               cmd_ch,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] c_CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic w_ss_rise, w_ss_fall, w_ss_level_unused;
    logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
    logic r_mosi_meta, r_mosi_sync;

    a2d_state_t            r_state, w_state_nxt;
    logic [FRAME_BITS-1:0] r_tx, w_tx_nxt;
    logic [FRAME_BITS-1:0] r_rx, w_rx_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    ch_t                   r_ptr, w_ptr_nxt;
    ch_t                   r_cmd, w_cmd_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;

    logic [DATA_W-1:0] w_ch_arr [NUM_CH];
    ch_t               w_rx_ch;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (SS_n),
        .o_level (w_ss_level_unused),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (SCLK),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // MOSI needs only its level; two flops keep it aligned with the SCLK edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_meta <= 1'b1;
            r_mosi_sync <= 1'b1;
        end else begin
            r_mosi_meta <= MOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
            assign w_ch_arr[g] = chan_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_rx_ch = r_rx[CH_LSB +: CH_W];

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_cmd_nxt   = r_cmd;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                // Channel data is latched once here so mid-frame changes cannot tear the word.
                if (w_ss_fall) begin
                    w_tx_nxt    = {{PAD_W{1'b0}}, w_ch_arr[r_ptr]};
                    w_cnt_nxt   = '0;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // End of frame wins over any SCLK edge seen in the same clock.
                if (w_ss_rise) begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_ptr_nxt  = w_rx_ch;
                        w_cmd_nxt  = w_rx_ch;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_rx_nxt = {r_rx[FRAME_BITS-2:0], r_mosi_sync};
                    if (r_cnt != c_CNT_SAT) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (w_sclk_fall && (r_cnt != '0)) begin
                    w_tx_nxt = {r_tx[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_cmd   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cmd   <= w_cmd_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign MISO       = r_tx[FRAME_BITS-1];
    assign cmd_ch     = r_cmd;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
//------------------------------------------------------------------------------
// Module   : tb_a2d_spi_resp
// Desc     : Directed self-checking bench for the SPI A2D responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_a2d_spi_resp;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] chan_data;
    logic [2:0]  cmd_ch;
    logic        frame_done;
    logic        frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_err   = 0;

    int          mid_bit = -1;
    int          mid_ch  = 0;
    logic [11:0] mid_val = '0;

    a2d_spi_resp u_dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .chan_data  (chan_data),
        .cmd_ch     (cmd_ch),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        chan_data[k*12 +: 12] = v;
    endtask

    // end_mode: 0 = SS_n rise after SCLK high, 1 = SS_n rise with SCLK fall, 2 = leave frame open
    task automatic spi_frame(input logic [15:0] cmd, input int nrise, input int half,
                             input int end_mode, output logic [15:0] rx);
        rx = '0;
        #1 SS_n = 1'b0;
        repeat (6) @(posedge clk);
        for (int i = 0; i < nrise; i++) begin
            if (i == mid_bit) chan_data[mid_ch*12 +: 12] = mid_val;
            #1;
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (half) @(posedge clk);
            #1;
            rx   = {rx[14:0], MISO};
            SCLK = 1'b1;
            repeat (half) @(posedge clk);
        end
        if (end_mode == 0) begin
            #1 SS_n = 1'b1;
        end else if (end_mode == 1) begin
            #1;
            SCLK = 1'b0;
            SS_n = 1'b1;
            repeat (6) @(posedge clk);
            #1 SCLK = 1'b1;
        end
        if (end_mode != 2) repeat (8) @(posedge clk);
    endtask

    logic [15:0] rx;
    int          d0, e0;

    initial begin
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b1;
        chan_data = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_cmd_ch", 32'(cmd_ch), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Basic two-frame exchange
        set_ch(0, 12'hABC);
        set_ch(5, 12'h123);
        d0 = n_done; e0 = n_err;
        spi_frame(16'h2800, 16, 4, 0, rx);
        check("f1_miso", 32'(rx), 32'h0ABC);
        check("f1_cmd_ch", 32'(cmd_ch), 32'd5);
        check("f1_done", 32'(n_done - d0), 32'd1);
        check("f1_err", 32'(n_err - e0), 32'd0);
        spi_frame(16'h0000, 16, 4, 0, rx);
        check("f2_miso", 32'(rx), 32'h0123);
        check("f2_cmd_ch", 32'(cmd_ch), 32'd0);

        // Pipelined sweep: each frame returns the channel commanded one frame earlier
        for (int k = 0; k < 8; k++) set_ch(k, 12'(k * 12'h101));
        d0 = n_done;
        for (int k = 0; k < 8; k++) begin
            spi_frame(16'(k << 11), 16, 4, 0, rx);
            check($sformatf("sweep%0d_miso", k), 32'(rx),
                  (k == 0) ? 32'h0000 : 32'((k - 1) * 12'h101));
            check($sformatf("sweep%0d_cmd_ch", k), 32'(cmd_ch), 32'(k));
        end
        check("sweep_done", 32'(n_done - d0), 32'd8);

        // Short frame: error pulse, state untouched
        d0 = n_done; e0 = n_err;
        spi_frame(16'h1000, 12, 4, 0, rx);
        check("short_err", 32'(n_err - e0), 32'd1);
        check("short_done", 32'(n_done - d0), 32'd0);
        check("short_cmd_ch", 32'(cmd_ch), 32'd7);
        spi_frame(16'h1800, 16, 4, 0, rx);
        check("after_short_miso", 32'(rx), 32'h0707);
        check("after_short_cmd_ch", 32'(cmd_ch), 32'd3);

        // Channel data changes mid-frame
        set_ch(3, 12'h555);
        mid_bit = 5; mid_ch = 3; mid_val = 12'hAAA;
        spi_frame(16'h1800, 16, 4, 0, rx);
        mid_bit = -1;
        check("mid_miso", 32'(rx), 32'h0555);
        spi_frame(16'h1800, 16, 4, 0, rx);
        check("mid_next_miso", 32'(rx), 32'h0AAA);
        check("mid_cmd_ch", 32'(cmd_ch), 32'd3);

        // Reset after 7 rises
        spi_frame(16'h3800, 7, 4, 2, rx);
        d0 = n_done; e0 = n_err;
        #1;
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_miso_in", 32'(MISO), 32'd0);
        check("mrst_cmd_ch_in", 32'(cmd_ch), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mrst_miso", 32'(MISO), 32'd0);
        check("mrst_cmd_ch", 32'(cmd_ch), 32'd0);
        check("mrst_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        set_ch(0, 12'h9C4);
        spi_frame(16'h2800, 16, 4, 0, rx);
        check("mrst_next_miso", 32'(rx), 32'h09C4);

        // Minimum and long SCLK phases give identical results
        spi_frame(16'h2800, 16, 4, 0, rx);
        check("fast_miso", 32'(rx), 32'h0505);
        check("fast_cmd_ch", 32'(cmd_ch), 32'd5);
        spi_frame(16'h2800, 16, 50, 0, rx);
        check("slow_miso", 32'(rx), 32'h0505);
        check("slow_cmd_ch", 32'(cmd_ch), 32'd5);

        // SS_n rise coincident with SCLK fall
        d0 = n_done; e0 = n_err;
        spi_frame(16'h3000, 16, 4, 1, rx);
        check("coinc_miso", 32'(rx), 32'h0505);
        check("coinc_done", 32'(n_done - d0), 32'd1);
        check("coinc_err", 32'(n_err - e0), 32'd0);
        check("coinc_cmd_ch", 32'(cmd_ch), 32'd6);
        spi_frame(16'h0000, 16, 4, 0, rx);
        check("coinc_next_miso", 32'(rx), 32'h0606);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
